// File: rtl/clock_time_ctrl.sv
// Alarm-clock timekeeping sequencer: 1 Hz tick, RUN-mode carry ripple, and a
// button-driven set mode with auto-repeat that pulses the counter-bank enables.
module clock_time_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_RATE   = 5_000_000
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Mode_Btn,
  input  logic       Inc_Btn,
  input  logic [5:0] Sec_Count,
  input  logic [5:0] Min_Count,
  output logic       Sec_En,
  output logic       Sec_LD,
  output logic       Min_En,
  output logic       Hour_En,
  output logic       AMin_En,
  output logic       AHour_En,
  output logic [2:0] Mode,
  output logic       Blink
);

  localparam logic [2:0] RUN       = 3'd0;
  localparam logic [2:0] SET_HOUR  = 3'd1;
  localparam logic [2:0] SET_MIN   = 3'd2;
  localparam logic [2:0] SET_AHOUR = 3'd3;
  localparam logic [2:0] SET_AMIN  = 3'd4;

  localparam int TW    = $clog2(TICKS_PER_SEC);
  localparam int HALF  = TICKS_PER_SEC / 2;
  localparam int BW    = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW    = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
  localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE   = RW'(REPEAT_RATE);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [2:0]    mode_sync;
  logic [2:0]    inc_sync;
  logic          mode_edge;
  logic          inc_edge;
  logic          inc_level;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
  logic [RW-1:0] rpt_thr;
  logic          rpt_fire;
  logic          inc_pulse;
  logic [BW-1:0] blink_cnt;
  logic          sec_wrap;
  logic          min_wrap;

  // Bits [1:0] are the synchroniser; bit 2 is the delayed copy for edge detect.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mode_sync <= 3'b000;
      inc_sync  <= 3'b000;
      mode_edge <= 1'b0;
      inc_edge  <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[1:0], Mode_Btn};
      inc_sync  <= {inc_sync[1:0], Inc_Btn};
      mode_edge <= mode_sync[1] & ~mode_sync[2];
      inc_edge  <= inc_sync[1] & ~inc_sync[2];
    end
  end

  assign inc_level = inc_sync[1];

  always_comb begin
    state_next = state;
    if (mode_edge) begin
      case (state)
        RUN:       state_next = SET_HOUR;
        SET_HOUR:  state_next = SET_MIN;
        SET_MIN:   state_next = SET_AHOUR;
        SET_AHOUR: state_next = SET_AMIN;
        default:   state_next = RUN;
      endcase
    end
  end

  assign tick      = (state == RUN) && (tick_cnt == TICK_LAST);
  assign sec_wrap  = (Sec_Count == 6'd59);
  assign min_wrap  = (Min_Count == 6'd59);
  assign rpt_thr   = rpt_phase ? RPT_RATE : RPT_DELAY;
  assign rpt_fire  = (rpt_cnt != '0) && (rpt_cnt == rpt_thr) && inc_level;
  // A Mode edge in the same cycle swallows any increment request.
  assign inc_pulse = (inc_edge || rpt_fire) && !mode_edge && (state != RUN);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state    <= RUN;
      tick_cnt <= '0;
    end else begin
      state <= state_next;
      if (state != RUN || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Repeat only arms from a fresh Inc edge, so a button held across a state
  // change stays silent until it is released and pressed again.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (mode_edge || state == RUN || !inc_level) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (inc_edge) begin
      rpt_cnt   <= RW'(1);
      rpt_phase <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= RW'(1);
      rpt_phase <= 1'b1;
    end else if (rpt_cnt != '0) begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      blink_cnt <= '0;
      Blink     <= 1'b0;
    end else if (state_next != state) begin
      blink_cnt <= '0;
      Blink     <= (state_next != RUN);
    end else if (state != RUN) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        Blink     <= ~Blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      Blink     <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      Sec_En   <= 1'b0;
      Sec_LD   <= 1'b0;
      Min_En   <= 1'b0;
      Hour_En  <= 1'b0;
      AMin_En  <= 1'b0;
      AHour_En <= 1'b0;
    end else begin
      Sec_En   <= tick;
      Sec_LD   <= mode_edge && (state == RUN);
      Min_En   <= (tick && sec_wrap) || (inc_pulse && state == SET_MIN);
      Hour_En  <= (tick && sec_wrap && min_wrap) || (inc_pulse && state == SET_HOUR);
      AMin_En  <= inc_pulse && (state == SET_AMIN);
      AHour_En <= inc_pulse && (state == SET_AHOUR);
    end
  end

  assign Mode = state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with small parameters (tick 8, delay 6, rate 3).
module tb_clock_time_ctrl;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       Mode_Btn = 1'b0;
  logic       Inc_Btn = 1'b0;
  logic [5:0] Sec_Count = 6'd0;
  logic [5:0] Min_Count = 6'd0;
  logic       Sec_En, Sec_LD, Min_En, Hour_En, AMin_En, AHour_En, Blink;
  logic [2:0] Mode;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int n_sec = 0, n_ld = 0, n_min = 0, n_hour = 0, n_amin = 0, n_ahour = 0;
  int hour_q[$];

  clock_time_ctrl #(
    .TICKS_PER_SEC(8),
    .REPEAT_DELAY (6),
    .REPEAT_RATE  (3)
  ) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .Mode_Btn (Mode_Btn),
    .Inc_Btn  (Inc_Btn),
    .Sec_Count(Sec_Count),
    .Min_Count(Min_Count),
    .Sec_En   (Sec_En),
    .Sec_LD   (Sec_LD),
    .Min_En   (Min_En),
    .Hour_En  (Hour_En),
    .AMin_En  (AMin_En),
    .AHour_En (AHour_En),
    .Mode     (Mode),
    .Blink    (Blink)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Sec_En)   n_sec++;
    if (Sec_LD)   n_ld++;
    if (Min_En)   n_min++;
    if (AMin_En)  n_amin++;
    if (AHour_En) n_ahour++;
    if (Hour_En) begin
      n_hour++;
      hour_q.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Clr = 1'b0;
    Mode_Btn = 1'b0;
    Inc_Btn = 1'b0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
  endtask

  task automatic press_mode();
    Mode_Btn = 1'b1;
    repeat (2) @(negedge Clk);
    Mode_Btn = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic press_inc();
    Inc_Btn = 1'b1;
    repeat (2) @(negedge Clk);
    Inc_Btn = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    #1 Clr = 1'b0;
    #1;
    outs = {Sec_En, Sec_LD, Min_En, Hour_En, AMin_En, AHour_En, Blink};
    total_cnt++;
    if (outs !== 7'b0) $display("FAIL reset_outs got %b want 0000000", outs);
    else pass_cnt++;
    total_cnt++;
    if (Mode !== 3'd0) $display("FAIL reset_mode got %0d want 0", Mode);
    else pass_cnt++;
    $display("test_reset: outs=%b mode=%0d", outs, Mode);
  endtask

  task automatic test_run_carry();
    do_reset();
    Sec_Count = 6'd58;
    Min_Count = 6'd59;
    repeat (7) @(negedge Clk);
    total_cnt++;
    if (Sec_En !== 1'b0) $display("FAIL tick_early got %b want 0", Sec_En);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if ({Sec_En, Min_En, Hour_En} !== 3'b100)
      $display("FAIL tick_sec58 got %b want 100", {Sec_En, Min_En, Hour_En});
    else pass_cnt++;
    Sec_Count = 6'd59;
    repeat (8) @(negedge Clk);
    total_cnt++;
    if ({Sec_En, Min_En, Hour_En} !== 3'b111)
      $display("FAIL tick_sec59 got %b want 111", {Sec_En, Min_En, Hour_En});
    else pass_cnt++;
    $display("test_run_carry: sec/min/hour=%b", {Sec_En, Min_En, Hour_En});
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_mode [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
    int ld0;
    int exp_ld;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ld0 = n_ld;
      exp_ld = (exp_mode[i] == 3'd1) ? 1 : 0;
      press_mode();
      total_cnt++;
      if (Mode !== exp_mode[i]) $display("FAIL mode_step%0d got %0d want %0d", i, Mode, exp_mode[i]);
      else pass_cnt++;
      total_cnt++;
      if (n_ld - ld0 !== exp_ld) $display("FAIL sec_ld_step%0d got %0d want %0d", i, n_ld - ld0, exp_ld);
      else pass_cnt++;
      $display("test_mode_cycle: press %0d mode=%0d sec_ld=%0d", i, Mode, n_ld - ld0);
    end
  endtask

  task automatic test_blink();
    do_reset();
    Mode_Btn = 1'b1;
    repeat (2) @(negedge Clk);
    Mode_Btn = 1'b0;
    @(negedge Clk);
    total_cnt++;
    if ({Mode, Blink} !== {3'd0, 1'b0}) $display("FAIL blink_pre got mode=%0d blink=%b want 0/0", Mode, Blink);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if ({Mode, Blink} !== {3'd1, 1'b1}) $display("FAIL blink_entry got mode=%0d blink=%b want 1/1", Mode, Blink);
    else pass_cnt++;
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (Blink !== 1'b1) $display("FAIL blink_hold got %b want 1", Blink);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (Blink !== 1'b0) $display("FAIL blink_toggle got %b want 0", Blink);
    else pass_cnt++;
    repeat (4) @(negedge Clk);
    total_cnt++;
    if (Blink !== 1'b1) $display("FAIL blink_toggle2 got %b want 1", Blink);
    else pass_cnt++;
    $display("test_blink: mode=%0d blink=%b", Mode, Blink);
  endtask

  task automatic test_set_min_no_carry();
    int s0, m0, h0;
    do_reset();
    press_mode();
    press_mode();
    Sec_Count = 6'd59;
    Min_Count = 6'd59;
    s0 = n_sec; m0 = n_min; h0 = n_hour;
    press_inc();
    repeat (20) @(negedge Clk);
    total_cnt++;
    if (n_min - m0 !== 1) $display("FAIL setmin_min_en got %0d want 1", n_min - m0);
    else pass_cnt++;
    total_cnt++;
    if (n_hour - h0 !== 0) $display("FAIL setmin_no_carry got %0d want 0", n_hour - h0);
    else pass_cnt++;
    total_cnt++;
    if (n_sec - s0 !== 0) $display("FAIL setmin_tick_halt got %0d want 0", n_sec - s0);
    else pass_cnt++;
    total_cnt++;
    if (Mode !== 3'd2) $display("FAIL setmin_mode got %0d want 2", Mode);
    else pass_cnt++;
    $display("test_set_min_no_carry: min=%0d hour=%0d sec=%0d", n_min - m0, n_hour - h0, n_sec - s0);
  endtask

  task automatic test_auto_repeat();
    int offs [5] = '{4, 10, 13, 16, 19};
    int c0;
    do_reset();
    press_mode();
    hour_q.delete();
    c0 = cyc;
    Inc_Btn = 1'b1;
    // Released early enough that the repeat due 21 edges after the first sample never fires.
    repeat (18) @(negedge Clk);
    Inc_Btn = 1'b0;
    repeat (12) @(negedge Clk);
    total_cnt++;
    if (hour_q.size() !== 5) $display("FAIL repeat_count got %0d want 5", hour_q.size());
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (k >= hour_q.size()) $display("FAIL repeat_time%0d got none want %0d", k, offs[k]);
      else if (hour_q[k] - c0 !== offs[k]) $display("FAIL repeat_time%0d got %0d want %0d", k, hour_q[k] - c0, offs[k]);
      else pass_cnt++;
    end
    $display("test_auto_repeat: pulses=%0d", hour_q.size());
  endtask

  task automatic test_mode_inc_same();
    int e0;
    do_reset();
    press_mode();
    e0 = n_hour + n_min + n_ahour + n_amin;
    Mode_Btn = 1'b1;
    Inc_Btn = 1'b1;
    repeat (2) @(negedge Clk);
    Mode_Btn = 1'b0;
    Inc_Btn = 1'b0;
    repeat (10) @(negedge Clk);
    total_cnt++;
    if (Mode !== 3'd2) $display("FAIL same_cycle_mode got %0d want 2", Mode);
    else pass_cnt++;
    total_cnt++;
    if (n_hour + n_min + n_ahour + n_amin - e0 !== 0)
      $display("FAIL same_cycle_enables got %0d want 0", n_hour + n_min + n_ahour + n_amin - e0);
    else pass_cnt++;
    $display("test_mode_inc_same: mode=%0d", Mode);
  endtask

  task automatic test_clr_mid_repeat();
    logic [6:0] outs;
    int a0, got;
    do_reset();
    repeat (3) press_mode();
    total_cnt++;
    if (Mode !== 3'd3) $display("FAIL clr_pre_mode got %0d want 3", Mode);
    else pass_cnt++;
    a0 = n_ahour;
    Inc_Btn = 1'b1;
    repeat (12) @(negedge Clk);
    total_cnt++;
    if (n_ahour - a0 !== 2) $display("FAIL clr_pre_repeat got %0d want 2", n_ahour - a0);
    else pass_cnt++;
    #2 Clr = 1'b0;
    #1;
    outs = {Sec_En, Sec_LD, Min_En, Hour_En, AMin_En, AHour_En, Blink};
    total_cnt++;
    if ({outs, Mode} !== 10'b0) $display("FAIL clr_outs got %b mode=%0d want 0", outs, Mode);
    else pass_cnt++;
    Inc_Btn = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    a0 = n_ahour;
    got = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (Sec_En && got < 0) got = i;
    end
    total_cnt++;
    if (got !== 8) $display("FAIL clr_first_tick got %0d want 8", got);
    else pass_cnt++;
    total_cnt++;
    if (n_ahour - a0 !== 0) $display("FAIL clr_no_pending got %0d want 0", n_ahour - a0);
    else pass_cnt++;
    $display("test_clr_mid_repeat: first tick after %0d edges", got);
  endtask

  initial begin
    test_reset();
    test_run_carry();
    test_mode_cycle();
    test_blink();
    test_set_min_no_carry();
    test_auto_repeat();
    test_mode_inc_same();
    test_clr_mid_repeat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
